// File: rtl/mem_cmd_ctrl_if.sv
// Byte-stream and memory-port bundle for mem_cmd_ctrl.
// Signals:
//   rx_tdata/rx_tvalid/rx_tready : command bytes from the UART receiver
//   tx_tdata/tx_tvalid/tx_tready : response bytes to the UART transmitter
//   mem_addr/mem_we/mem_wdata    : single-port memory write side
//   mem_re/mem_rdata             : memory read side, rdata valid the cycle after mem_re
// Modports: master = controller side, slave = UART/memory side.
interface mem_cmd_ctrl_if #(
  parameter int unsigned ADDR_W = 7
);
  logic [7:0]        rx_tdata;
  logic              rx_tvalid;
  logic              rx_tready;
  logic [7:0]        tx_tdata;
  logic              tx_tvalid;
  logic              tx_tready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic              mem_re;
  logic [7:0]        mem_rdata;

  modport master (
    input  rx_tdata, rx_tvalid,
    output rx_tready,
    output tx_tdata, tx_tvalid,
    input  tx_tready,
    output mem_addr, mem_we, mem_wdata, mem_re,
    input  mem_rdata
  );

  modport slave (
    output rx_tdata, rx_tvalid,
    input  rx_tready,
    input  tx_tdata, tx_tvalid,
    output tx_tready,
    input  mem_addr, mem_we, mem_wdata, mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/mem_cmd_ctrl.sv
// UART command controller for the 128x8 lookup memory.
// Parses 'W' addr data (write, ACK), 'R' addr (read, one data byte) and
// 'D' addr count (dump count bytes, ACK when count is 0). Bad opcode or
// out-of-range address yields NAK. Idle gaps inside a command abort it.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   bus            : rx/tx byte streams and memory port (master modport)
//   o_disp_data    : last byte written to or read from memory
//   o_busy         : controller not idle
//   o_timeout_err  : one-cycle pulse when a command times out
module mem_cmd_ctrl #(
  parameter int unsigned ADDR_W         = 7,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
  parameter logic [7:0]  ACK            = 8'h06,
  parameter logic [7:0]  NAK            = 8'h15
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  mem_cmd_ctrl_if.master        bus,
  output logic [7:0]            o_disp_data,
  output logic                  o_busy,
  output logic                  o_timeout_err
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StGetAddr, StGetData, StGetCount, StMemWr, StMemRd, StWaitRd, StSend
  } state_e;

  typedef enum logic [1:0] {CmdWr, CmdRd, CmdDump} cmd_e;

  state_e            r_state,     w_state_nxt;
  cmd_e              r_cmd,       w_cmd_nxt;
  logic [ADDR_W-1:0] r_addr,      w_addr_nxt;
  logic [7:0]        r_count,     w_count_nxt;
  logic [TmoW-1:0]   r_tmo,       w_tmo_nxt;
  logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic              r_mem_we,    w_mem_we_nxt;
  logic [7:0]        r_mem_wdata, w_mem_wdata_nxt;
  logic              r_mem_re,    w_mem_re_nxt;
  logic [7:0]        r_tx_tdata,  w_tx_tdata_nxt;
  logic              r_tx_tvalid, w_tx_tvalid_nxt;
  logic [7:0]        r_disp,      w_disp_nxt;
  logic              r_tmo_err,   w_tmo_err_nxt;

  logic              w_rx_tready;
  logic              w_rx_acc;
  logic              w_addr_ok;
  logic              w_in_get;

  assign w_in_get    = (r_state == StGetAddr) || (r_state == StGetData) ||
                       (r_state == StGetCount);
  assign w_rx_tready = (r_state == StIdle) || w_in_get;
  assign w_rx_acc    = bus.rx_tvalid & w_rx_tready;
  // Upper address bits beyond the memory size must be zero.
  assign w_addr_ok   = (bus.rx_tdata >> ADDR_W) == 8'd0;

  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_nxt       = r_cmd;
    w_addr_nxt      = r_addr;
    w_count_nxt     = r_count;
    w_tmo_nxt       = '0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_we_nxt    = 1'b0;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_re_nxt    = 1'b0;
    w_tx_tdata_nxt  = r_tx_tdata;
    w_tx_tvalid_nxt = r_tx_tvalid;
    w_disp_nxt      = r_disp;
    w_tmo_err_nxt   = 1'b0;

    case (r_state)
      StIdle: begin
        w_count_nxt = '0;
        if (w_rx_acc) begin
          case (bus.rx_tdata)
            8'h57: begin w_cmd_nxt = CmdWr;   w_state_nxt = StGetAddr; end
            8'h52: begin w_cmd_nxt = CmdRd;   w_state_nxt = StGetAddr; end
            8'h44: begin w_cmd_nxt = CmdDump; w_state_nxt = StGetAddr; end
            default: begin
              w_tx_tdata_nxt  = NAK;
              w_tx_tvalid_nxt = 1'b1;
              w_state_nxt     = StSend;
            end
          endcase
        end
      end
      StGetAddr: begin
        if (w_rx_acc) begin
          if (!w_addr_ok) begin
            w_tx_tdata_nxt  = NAK;
            w_tx_tvalid_nxt = 1'b1;
            w_state_nxt     = StSend;
          end else begin
            w_addr_nxt = bus.rx_tdata[ADDR_W-1:0];
            case (r_cmd)
              CmdWr:   w_state_nxt = StGetData;
              CmdDump: w_state_nxt = StGetCount;
              default: begin
                w_mem_addr_nxt = bus.rx_tdata[ADDR_W-1:0];
                w_mem_re_nxt   = 1'b1;
                w_state_nxt    = StMemRd;
              end
            endcase
          end
        end
      end
      StGetData: begin
        if (w_rx_acc) begin
          w_mem_addr_nxt  = r_addr;
          w_mem_wdata_nxt = bus.rx_tdata;
          w_mem_we_nxt    = 1'b1;
          w_state_nxt     = StMemWr;
        end
      end
      StGetCount: begin
        if (w_rx_acc) begin
          if (bus.rx_tdata == 8'd0) begin
            w_tx_tdata_nxt  = ACK;
            w_tx_tvalid_nxt = 1'b1;
            w_state_nxt     = StSend;
          end else begin
            w_count_nxt    = bus.rx_tdata;
            w_mem_addr_nxt = r_addr;
            w_mem_re_nxt   = 1'b1;
            w_state_nxt    = StMemRd;
          end
        end
      end
      StMemWr: begin
        w_disp_nxt      = r_mem_wdata;
        w_tx_tdata_nxt  = ACK;
        w_tx_tvalid_nxt = 1'b1;
        w_state_nxt     = StSend;
      end
      StMemRd: w_state_nxt = StWaitRd;
      StWaitRd: begin
        w_tx_tdata_nxt  = bus.mem_rdata;
        w_disp_nxt      = bus.mem_rdata;
        w_tx_tvalid_nxt = 1'b1;
        w_state_nxt     = StSend;
      end
      StSend: begin
        if (bus.tx_tready) begin
          w_tx_tvalid_nxt = 1'b0;
          // r_count holds bytes still owed including the one just sent.
          if (r_count > 8'd1) begin
            w_count_nxt    = r_count - 8'd1;
            w_addr_nxt     = r_addr + ADDR_W'(1);
            w_mem_addr_nxt = r_addr + ADDR_W'(1);
            w_mem_re_nxt   = 1'b1;
            w_state_nxt    = StMemRd;
          end else begin
            w_count_nxt = '0;
            w_state_nxt = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // Inter-byte timeout; an accepted byte leaves w_tmo_nxt at its zero default.
    if (w_in_get && !w_rx_acc) begin
      if (r_tmo == TmoLast) begin
        w_state_nxt   = StIdle;
        w_tmo_err_nxt = 1'b1;
      end else begin
        w_tmo_nxt = r_tmo + TmoW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cmd       <= CmdWr;
      r_addr      <= '0;
      r_count     <= '0;
      r_tmo       <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_re    <= 1'b0;
      r_tx_tdata  <= '0;
      r_tx_tvalid <= 1'b0;
      r_disp      <= '0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd       <= w_cmd_nxt;
      r_addr      <= w_addr_nxt;
      r_count     <= w_count_nxt;
      r_tmo       <= w_tmo_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_re    <= w_mem_re_nxt;
      r_tx_tdata  <= w_tx_tdata_nxt;
      r_tx_tvalid <= w_tx_tvalid_nxt;
      r_disp      <= w_disp_nxt;
      r_tmo_err   <= w_tmo_err_nxt;
    end
  end

  assign bus.rx_tready = w_rx_tready;
  assign bus.tx_tdata  = r_tx_tdata;
  assign bus.tx_tvalid = r_tx_tvalid;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_re    = r_mem_re;
  assign o_disp_data   = r_disp;
  assign o_busy        = (r_state != StIdle);
  assign o_timeout_err = r_tmo_err;

endmodule

// File: tb/tb_mem_cmd_ctrl.sv
// Directed bench for mem_cmd_ctrl with a 128x8 synchronous memory model.
module tb_mem_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] disp;
  logic       busy;
  logic       terr;
  logic       preload;

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt   = 0;
  int re_cnt   = 0;
  int to_cnt   = 0;

  logic [7:0] mem [0:127];
  logic [7:0] tx_log [$];
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = 8'h00;

  mem_cmd_ctrl_if #(.ADDR_W(7)) bus ();

  mem_cmd_ctrl #(
    .ADDR_W        (7),
    .TIMEOUT_CYCLES(16),
    .ACK           (8'h06),
    .NAK           (8'h15)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .bus          (bus),
    .o_disp_data  (disp),
    .o_busy       (busy),
    .o_timeout_err(terr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory model: preload addr value = addr, then behave as a 1-cycle read RAM.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem[i] <= i[7:0];
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Transfer logging, strobe counting and tx hold-under-backpressure check.
  always @(posedge clk) begin
    if (bus.tx_tvalid && bus.tx_tready) tx_log.push_back(bus.tx_tdata);
    if (bus.mem_we) we_cnt <= we_cnt + 1;
    if (bus.mem_re) re_cnt <= re_cnt + 1;
    if (terr) to_cnt <= to_cnt + 1;
    if (stall_q) check("tx_hold", {23'd0, bus.tx_tvalid, bus.tx_tdata}, {23'd0, 1'b1, stall_data});
    stall_q    <= bus.tx_tvalid && !bus.tx_tready && !rst;
    stall_data <= bus.tx_tdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the edge on which the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    bus.rx_tdata  = b;
    bus.rx_tvalid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.rx_tready) done = 1;
      step();
    end
    bus.rx_tvalid = 1'b0;
    if (!done) check("rx_accept", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int re0;
    int we0;
    int to0;
    rst           = 1'b1;
    preload       = 1'b1;
    bus.rx_tvalid = 1'b0;
    bus.rx_tdata  = 8'h00;
    bus.tx_tready = 1'b0;
    step();
    preload = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_tvalid", bus.tx_tvalid, 0);
    check("rst_tdata", bus.tx_tdata, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_re", bus.mem_re, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", terr, 0);
    check("rst_disp", disp, 0);
    check("rst_rxready", bus.rx_tready, 1);

    // Write 'W' 0x10 0xA5
    bus.tx_tready = 1'b1;
    tx_log.delete();
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'hA5);
    check("wr_we", bus.mem_we, 1);
    check("wr_addr", bus.mem_addr, 8'h10);
    check("wr_wdata", bus.mem_wdata, 8'hA5);
    check("wr_tvalid_early", bus.tx_tvalid, 0);
    step();
    check("wr_we_off", bus.mem_we, 0);
    check("wr_ack_valid", bus.tx_tvalid, 1);
    check("wr_ack_data", bus.tx_tdata, 8'h06);
    check("wr_disp", disp, 8'hA5);
    check("wr_busy", busy, 1);
    step();
    check("wr_done_tvalid", bus.tx_tvalid, 0);
    check("wr_done_busy", busy, 0);
    check("wr_we_count", we_cnt, 1);
    check("wr_log_n", tx_log.size(), 1);
    if (tx_log.size() > 0) check("wr_log0", tx_log[0], 8'h06);

    // Read 'R' 0x10
    tx_log.delete();
    re0 = re_cnt;
    send_byte(8'h52);
    send_byte(8'h10);
    check("rd_re", bus.mem_re, 1);
    check("rd_addr", bus.mem_addr, 8'h10);
    check("rd_tvalid0", bus.tx_tvalid, 0);
    step();
    check("rd_re_off", bus.mem_re, 0);
    check("rd_tvalid1", bus.tx_tvalid, 0);
    step();
    check("rd_tvalid2", bus.tx_tvalid, 1);
    check("rd_tdata", bus.tx_tdata, 8'hA5);
    check("rd_disp", disp, 8'hA5);
    step();
    check("rd_busy", busy, 0);
    check("rd_re_count", re_cnt - re0, 1);
    check("rd_log_n", tx_log.size(), 1);

    // Dump 'D' 0x7E 0x04 with toggling tx_tready; address wraps past 0x7F
    bus.tx_tready = 1'b0;
    tx_log.delete();
    send_byte(8'h44);
    send_byte(8'h7E);
    send_byte(8'h04);
    for (int i = 0; i < 200 && !(tx_log.size() == 4 && !busy); i++) begin
      bus.tx_tready = ~bus.tx_tready;
      step();
    end
    check("dump_n", tx_log.size(), 4);
    if (tx_log.size() == 4) begin
      check("dump_b0", tx_log[0], 8'h7E);
      check("dump_b1", tx_log[1], 8'h7F);
      check("dump_b2", tx_log[2], 8'h00);
      check("dump_b3", tx_log[3], 8'h01);
    end
    check("dump_disp", disp, 8'h01);
    check("dump_busy", busy, 0);

    // Dump with count 0 -> ACK only
    bus.tx_tready = 1'b1;
    tx_log.delete();
    re0 = re_cnt;
    send_byte(8'h44);
    send_byte(8'h05);
    send_byte(8'h00);
    check("dump0_valid", bus.tx_tvalid, 1);
    check("dump0_data", bus.tx_tdata, 8'h06);
    step();
    step();
    check("dump0_n", tx_log.size(), 1);
    check("dump0_re", re_cnt - re0, 0);
    check("dump0_busy", busy, 0);

    // Unknown opcode -> NAK
    tx_log.delete();
    send_byte(8'h41);
    check("nak_valid", bus.tx_tvalid, 1);
    check("nak_data", bus.tx_tdata, 8'h15);
    step();
    check("nak_busy", busy, 0);

    // Out-of-range address -> NAK, no read
    re0 = re_cnt;
    send_byte(8'h52);
    send_byte(8'h80);
    check("badaddr_valid", bus.tx_tvalid, 1);
    check("badaddr_data", bus.tx_tdata, 8'h15);
    check("badaddr_re", bus.mem_re, 0);
    step();
    step();
    check("badaddr_re_count", re_cnt - re0, 0);
    check("badaddr_log_n", tx_log.size(), 2);

    // Timeout after 'W' 0x20 then silence
    tx_log.delete();
    we0 = we_cnt;
    to0 = to_cnt;
    send_byte(8'h57);
    send_byte(8'h20);
    repeat (15) step();
    check("to_early_err", terr, 0);
    check("to_early_busy", busy, 1);
    step();
    check("to_err", terr, 1);
    check("to_busy", busy, 0);
    step();
    check("to_err_off", terr, 0);
    check("to_pulses", to_cnt - to0, 1);
    check("to_we", we_cnt - we0, 0);
    check("to_tx", tx_log.size(), 0);

    // Reset while holding a NAK under backpressure
    bus.tx_tready = 1'b0;
    send_byte(8'h41);
    step();
    step();
    check("rstsend_held", bus.tx_tvalid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstsend_tvalid", bus.tx_tvalid, 0);
    check("rstsend_busy", busy, 0);
    check("rstsend_tdata", bus.tx_tdata, 0);
    bus.tx_tready = 1'b1;
    tx_log.delete();
    send_byte(8'h52);
    send_byte(8'h10);
    step();
    step();
    step();
    check("post_rst_n", tx_log.size(), 1);
    if (tx_log.size() == 1) check("post_rst_data", tx_log[0], 8'hA5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_cmd_ctrl.md
# mem_cmd_ctrl

UART command controller that sequences all accesses to the 128x8 lookup memory. Sits between `uart_rx` (byte stream in), the memory (single synchronous port) and `uart_tx` (byte stream out). Parses write/read/dump commands, drives the memory port, returns response bytes, and holds the last accessed byte for the seven-segment display.

## Interface
- `ADDR_W`, 7, memory address width; addresses wrap mod 2^ADDR_W.
- `TIMEOUT_CYCLES`, 2_500_000, idle cycles allowed between bytes of one command (100 ms at 25 MHz).
- `ACK`, 8'h06, write/empty-dump acknowledge byte.
- `NAK`, 8'h15, error response byte.

One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active high.
- `rx_tdata`  in  8  received byte.
- `rx_tvalid`  in  1  received byte valid.
- `rx_tready`  out  1  controller accepts byte.
- `tx_tdata`  out  8  response byte.
- `tx_tvalid`  out  1  response valid.
- `tx_tready`  in  1  transmitter accepts byte.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_we`  out  1  write strobe, one cycle.
- `mem_wdata`  out  8  write data.
- `mem_re`  out  1  read strobe; `mem_rdata` valid the cycle after.
- `mem_rdata`  in  8  read data.
- `disp_data`  out  8  last byte written or read.
- `busy`  out  1  state != IDLE.
- `timeout_err`  out  1  one-cycle pulse on command timeout.

## Operation
- Rx byte accepted on edge where `rx_tvalid & rx_tready`. `rx_tready`=1 only in IDLE, GET_ADDR, GET_DATA, GET_COUNT.
- Commands: 8'h57 'W' addr data -> write, reply ACK. 8'h52 'R' addr -> reply mem[addr]. 8'h44 'D' addr count -> reply count bytes mem[addr..addr+count-1], address wraps; count 0 -> reply ACK only.
- Any other command byte -> reply NAK, back to IDLE. Address byte with bits [7:ADDR_W] nonzero -> NAK, no memory access.
- States: IDLE -> GET_ADDR (on W/R/D) -> GET_DATA (W) / GET_COUNT (D) / MEM_RD (R). GET_DATA -> MEM_WR -> SEND(ACK). MEM_RD -> WAIT_RD -> SEND(data). SEND -> IDLE on handshake, or -> MEM_RD for next dump byte while remaining count != 0.
- MEM_WR: `mem_we`=1, `mem_addr`, `mem_wdata` valid for exactly that cycle; `disp_data` <= wdata.
- MEM_RD: `mem_re`=1 one cycle. WAIT_RD: `tx_tdata` <= `mem_rdata`, `disp_data` <= `mem_rdata`.
- SEND: `tx_tvalid`=1, `tx_tdata` stable until `tx_tready`; unlimited back-pressure, no timeout in SEND.
- Dump counter 8 bits; address increments after each sent byte, mod 2^ADDR_W (addr 127 + 1 -> 0).
- Timeout: counter cleared on every accepted byte and in IDLE; counts in GET_* states; at TIMEOUT_CYCLES-1 -> IDLE, `timeout_err` pulse, no response byte.

## Timing
- Reset: all outputs 0 (`tx_tvalid`, `mem_we`, `mem_re`, `busy`, `timeout_err`, `disp_data`, `mem_addr`, `tx_tdata`), state IDLE, counters 0; `rx_tready` 1 from first cycle after reset.
- All outputs registered except `rx_tready` and `busy` (decoded from state register).
- Read: address accepted at edge E0 -> `mem_re` high cycle after E0 -> `tx_tvalid` high after E2 (2 cycles after accept).
- Write: data accepted at E0 -> `mem_we` high cycle after E0 -> ACK `tx_tvalid` after E1.
- NAK: `tx_tvalid` high the cycle after offending byte accepted.
- Dump steady state with `tx_tready`=1: one byte per 3 cycles.
- Reset mid-command: aborted at that edge; a `mem_we` already high in that cycle completes; pending tx byte dropped (`tx_tvalid` 0 after reset edge).
- No rx acceptance while SEND pending; upstream must hold or drop.

## Test plan
- Reset then 'W' 0x10 0xA5 -> one `mem_we` pulse addr 0x10 data 0xA5, tx ACK 0x06, `disp_data`=0xA5, `busy` back to 0.
- 'R' 0x10 after above -> `mem_re` one cycle, `tx_tvalid` 2 cycles after addr accept, `tx_tdata`=0xA5.
- 'D' 0x7E 0x04 with memory preloaded addr value = addr, `tx_tready` toggling 1/0 -> bytes 0x7E,0x7F,0x00,0x01, each held until handshake; 'D' 0x05 0x00 -> ACK only.
- Byte 0x41 in IDLE -> NAK 0x15; 'R' 0x80 -> NAK, no `mem_re`.
- 'W' 0x20 then silence TIMEOUT_CYCLES (set 16) -> `timeout_err` one-cycle pulse, IDLE, no tx, no `mem_we`.
- Assert `rst` while in SEND with `tx_tready`=0 -> `tx_tvalid` 0 next cycle, state IDLE, subsequent 'R' works normally.
